// File: rtl/ratio_meter_if.sv
// Bus between ratio_meter and its user: measurement control in, period/high-time reports out.
interface ratio_meter_if #(parameter int SIZE = 8);
  logic            enable;
  logic            div_in;
  logic [SIZE-1:0] P;
  logic [SIZE-1:0] H;
  logic            valid;
  logic            upd;
  logic            err;

  modport master (
    output enable,
    output div_in,
    input  P,
    input  H,
    input  valid,
    input  upd,
    input  err
  );

  modport slave (
    input  enable,
    input  div_in,
    output P,
    output H,
    output valid,
    output upd,
    output err
  );
endinterface

// File: rtl/ratio_meter.sv
// Measures period and high time of div_in in cycles of the reference clock `in`.
// Define METER_SYNC_EN to add a two-flop synchronizer ahead of the sampling flop.
module ratio_meter #(
  parameter int SIZE = 8
) (
  input  logic          in,
  input  logic          reset,
  ratio_meter_if.slave  bus
);

  localparam logic [SIZE-1:0] CNT_MAX = '1;
  localparam logic [SIZE-1:0] CNT_ONE = SIZE'(1);

  typedef enum logic [1:0] {
    IDLE,
    SEEK,
    MEASURE
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            s;
  logic            s_d;
  logic            rise;
  logic [SIZE-1:0] cnt;
  logic [SIZE-1:0] cnt_next;
  logic [SIZE-1:0] hcnt;
  logic [SIZE-1:0] hcnt_next;
  logic [SIZE-1:0] p_q;
  logic [SIZE-1:0] p_next;
  logic [SIZE-1:0] h_q;
  logic [SIZE-1:0] h_next;
  logic            valid_q;
  logic            valid_next;
  logic            upd_q;
  logic            upd_next;
  logic            err_q;
  logic            err_next;

`ifdef METER_SYNC_EN
  logic sync1;
  logic sync2;

  always_ff @(posedge in or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      s     <= 1'b0;
      s_d   <= 1'b0;
    end else begin
      sync1 <= bus.div_in;
      sync2 <= sync1;
      s     <= sync2;
      s_d   <= s;
    end
  end
`else
  always_ff @(posedge in or negedge reset) begin
    if (!reset) begin
      s   <= 1'b0;
      s_d <= 1'b0;
    end else begin
      s   <= bus.div_in;
      s_d <= s;
    end
  end
`endif

  assign rise = s & ~s_d;

  always_ff @(posedge in or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      hcnt    <= '0;
      p_q     <= '0;
      h_q     <= '0;
      valid_q <= 1'b0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      hcnt    <= hcnt_next;
      p_q     <= p_next;
      h_q     <= h_next;
      valid_q <= valid_next;
      upd_q   <= upd_next;
      err_q   <= err_next;
    end
  end

  // A rise arriving together with cnt at its maximum is reported, not treated as overflow.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    hcnt_next  = hcnt;
    p_next     = p_q;
    h_next     = h_q;
    valid_next = valid_q;
    upd_next   = 1'b0;
    err_next   = err_q;

    if (!bus.enable) begin
      state_next = IDLE;
      cnt_next   = '0;
      hcnt_next  = '0;
      valid_next = 1'b0;
      err_next   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_next = SEEK;
          cnt_next   = '0;
          hcnt_next  = '0;
          valid_next = 1'b0;
          err_next   = 1'b0;
        end
        SEEK: begin
          if (rise) begin
            state_next = MEASURE;
            cnt_next   = CNT_ONE;
            hcnt_next  = CNT_ONE;
          end
        end
        MEASURE: begin
          if (rise) begin
            p_next     = cnt;
            h_next     = hcnt;
            upd_next   = 1'b1;
            valid_next = 1'b1;
            cnt_next   = CNT_ONE;
            hcnt_next  = CNT_ONE;
          end else if (cnt == CNT_MAX) begin
            state_next = SEEK;
            err_next   = 1'b1;
            valid_next = 1'b0;
            p_next     = '0;
            h_next     = '0;
            cnt_next   = '0;
            hcnt_next  = '0;
          end else begin
            cnt_next  = cnt + CNT_ONE;
            hcnt_next = hcnt + SIZE'(s);
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign bus.P     = p_q;
  assign bus.H     = h_q;
  assign bus.valid = valid_q;
  assign bus.upd   = upd_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_ratio_meter.sv
// Bench for ratio_meter: random and directed div_in patterns, reports checked by a queue-based scoreboard.
module tb_ratio_meter;

  localparam int SIZE    = 8;
  localparam int MAX_CNT = (1 << SIZE) - 1;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  ratio_meter_if #(.SIZE(SIZE)) bus();

  ratio_meter #(.SIZE(SIZE)) dut (
    .in    (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    bit is_err;
    int p;
    int h;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  bit   prev_bit  = 1'b0;
  bit   enabled   = 1'b0;
  bit   measuring = 1'b0;
  bit   hist[$];
  bit   exp_valid = 1'b0;
  bit   exp_err   = 1'b0;
  int   exp_p     = 0;
  int   exp_h     = 0;

  task automatic check_output(input string name, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Reference: a period is the cycle list between two driven rises; an overflow is 255 cycles with no rise.
  task automatic model_step(input bit b);
    bit   r;
    exp_t e;
    int   ones;
    r        = b && !prev_bit;
    prev_bit = b;
    if (!enabled) return;
    if (!measuring) begin
      if (r) begin
        measuring = 1'b1;
        hist.delete();
        hist.push_back(b);
      end
    end else if (r) begin
      ones = 0;
      foreach (hist[i]) ones += int'(hist[i]);
      e.is_err  = 1'b0;
      e.p       = hist.size();
      e.h       = ones;
      exp_q.push_back(e);
      exp_valid = 1'b1;
      exp_p     = e.p;
      exp_h     = e.h;
      hist.delete();
      hist.push_back(b);
    end else if (hist.size() == MAX_CNT) begin
      e.is_err  = 1'b1;
      e.p       = 0;
      e.h       = 0;
      exp_q.push_back(e);
      exp_err   = 1'b1;
      exp_valid = 1'b0;
      exp_p     = 0;
      exp_h     = 0;
      measuring = 1'b0;
      hist.delete();
    end else begin
      hist.push_back(b);
    end
  endtask

  task automatic step_bit(input bit b);
    @(negedge clk);
    bus.div_in = b;
    model_step(b);
  endtask

  task automatic apply_stimulus(input int hi, input int lo, input int n);
    for (int k = 0; k < n; k++) begin
      repeat (hi) step_bit(1'b1);
      repeat (lo) step_bit(1'b0);
    end
  endtask

  task automatic set_enable(input bit v);
    repeat (6) step_bit(1'b0);
    @(negedge clk);
    bus.div_in = 1'b0;
    model_step(1'b0);
    bus.enable = v;
    enabled    = v;
    measuring  = 1'b0;
    hist.delete();
    if (!v) begin
      exp_valid = 1'b0;
      exp_err   = 1'b0;
    end
    repeat (6) step_bit(1'b0);
  endtask

  task automatic check_status(input string tag);
    repeat (6) step_bit(1'b0);
    check_output({tag, "_valid"}, int'(bus.valid), int'(exp_valid));
    check_output({tag, "_err"},   int'(bus.err),   int'(exp_err));
    check_output({tag, "_P"},     int'(bus.P),     exp_p);
    check_output({tag, "_H"},     int'(bus.H),     exp_h);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_P"},     int'(bus.P),     0);
    check_output({tag, "_H"},     int'(bus.H),     0);
    check_output({tag, "_valid"}, int'(bus.valid), 0);
    check_output({tag, "_upd"},   int'(bus.upd),   0);
    check_output({tag, "_err"},   int'(bus.err),   0);
  endtask

  // Monitor: every upd and every err onset must match the next scoreboard entry.
  initial begin
    exp_t e;
    bit   err_prev;
    err_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.upd === 1'b1) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_upd", int'(bus.P), -1);
        end else begin
          e = exp_q.pop_front();
          check_output("upd_kind",  0,               int'(e.is_err));
          check_output("upd_P",     int'(bus.P),     e.p);
          check_output("upd_H",     int'(bus.H),     e.h);
          check_output("upd_valid", int'(bus.valid), 1);
        end
      end
      if (bus.err === 1'b1 && !err_prev) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_err", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_output("err_kind",  1,               int'(e.is_err));
          check_output("err_P",     int'(bus.P),     0);
          check_output("err_H",     int'(bus.H),     0);
          check_output("err_valid", int'(bus.valid), 0);
        end
      end
      err_prev = (bus.err === 1'b1);
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    bus.enable = 1'b0;
    bus.div_in = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    set_enable(1'b1);
    apply_stimulus(2, 2, 6);
    check_status("p4");
    apply_stimulus(3, 4, 5);
    check_status("p7");
    apply_stimulus(1, 1, 8);
    check_status("p2");

    for (int k = 0; k < 20; k++) begin
      apply_stimulus(int'($urandom_range(1, 6)), int'($urandom_range(1, 8)), 2);
    end
    check_status("rand");

    // Largest measurable period, closed by an explicit rise so quiet time cannot overflow it.
    apply_stimulus(1, MAX_CNT - 1, 3);
    step_bit(1'b1);
    check_status("p255");

    step_bit(1'b1);
    repeat (300) step_bit(1'b0);
    check_status("ovf");
    apply_stimulus(2, 2, 4);
    check_status("after_ovf");

    apply_stimulus(2, 2, 3);
    step_bit(1'b1);
    set_enable(1'b0);
    check_status("disabled");
    set_enable(1'b1);
    apply_stimulus(3, 3, 4);
    check_status("reenable");

    apply_stimulus(2, 2, 3);
    repeat (6) step_bit(1'b0);
    check_output("pre_reset_queue", exp_q.size(), 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    prev_bit  = 1'b0;
    measuring = 1'b0;
    hist.delete();
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    exp_p     = 0;
    exp_h     = 0;
    repeat (2) @(negedge clk);
    bus.div_in = 1'b1;
    @(negedge clk);
    rst_n      = 1'b1;
    bus.div_in = 1'b1;
    model_step(1'b1);
    step_bit(1'b1);
    apply_stimulus(2, 3, 4);
    check_status("post_reset");

    repeat (8) step_bit(1'b0);
    check_output("final_queue", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ratio_meter.md
# ratio_meter

Measures the division ratio of a clock derived from `in`, such as the output of the frequency divider. It counts how many `in` cycles lie between consecutive rising edges of `div_in`, and how many of those cycles `div_in` was high. It reports the period as `P` in the same encoding the divider accepts, so firmware and the bench can close the loop: program P, divide, measure, compare. It sits beside the divider on the same `in` clock domain.

## Interface
- `SIZE`, 8: width of the measured period and high-time fields; matches the divider's P width.
- `in`  input  1  clock (reference clock, same one that drives the divider)
- `reset`  input  1  asynchronous, active-low reset
- `enable`  input  1  measurement enable; low forces IDLE
- `div_in`  input  1  divided clock under measurement, single-bit level
- `P`  output  SIZE  last measured period in `in` cycles
- `H`  output  SIZE  last measured high time in `in` cycles
- `valid`  output  1  level; high while `P`/`H` hold a measurement of the current run
- `upd`  output  1  one-cycle strobe on each new `P`/`H` capture
- `err`  output  1  sticky overflow flag: no rising edge within 2^SIZE-1 cycles

## Operation
- Sampling:
  - `s` is `div_in` registered once; `s_d` is `s` delayed one cycle.
  - `rise = s & !s_d`.
  - Sampling flops run in every state and reset to 0.
- Counters:
  - `cnt` and `hcnt` are each SIZE bits and hold at 0 in IDLE.
  - On a rise in SEEK or MEASURE: `cnt<=1`, `hcnt<=1`.
  - Otherwise in MEASURE: `cnt<=cnt+1`, `hcnt<=hcnt+s`.
- States:
  - IDLE: entered on reset or `enable`=0. Clears `valid` and `err`; `P`/`H` hold their last values. Goes to SEEK on the cycle after `enable`=1.
  - SEEK: waits for the first rise, which starts a partial period and is never reported. Counters load per the rules above. Goes to MEASURE.
  - MEASURE: on each rise, `P<=cnt`, `H<=hcnt`, `upd<=1`, `valid<=1`, counters reload, stays in MEASURE.
- Overflow:
  - Trigger: in MEASURE, `cnt`=2^SIZE-1 with no rise this cycle.
  - Response: `err<=1`, `valid<=0`, `P<=0`, `H<=0`, go to SEEK.
  - `err` stays set until `enable`=0 or reset.
- Simultaneous rise and `cnt`=2^SIZE-1: the measurement wins (`P`=2^SIZE-1) and no overflow is flagged.
- Constant `div_in`, which includes the divider's P=1 output of constant 0: no rises, so overflow repeats every 2^SIZE-1 cycles.
- `enable` dropping mid-period: the partial period is discarded, with no `upd`.
- Spurious rise after reset release while `div_in` is high: it lands in SEEK, so no false measurement is produced.
- Measurable range: P from 2 (`div_in` toggling every `in` cycle) to 2^SIZE-1.

## Timing
- Reset values: `P`=0, `H`=0, `valid`=0, `upd`=0, `err`=0, state IDLE, `cnt`=`hcnt`=0.
- `upd` is high for exactly one cycle, starting 2 `in` edges after the edge that first samples `div_in` high (4 with METER_SYNC_EN).
- `valid` rises in the same cycle as the first `upd` of a run.
- `P`/`H` change only in `upd` cycles, or to 0 in the cycle `err` sets.
- First `upd` after `enable` rises: no earlier than one full `div_in` period plus the latency above.
- Asserting `reset` mid-operation: all outputs return to their reset values immediately, without waiting for a clock edge.

## Configuration
- `METER_SYNC_EN`:
  - Defined: two additional synchronizer flops (reset 0) sit ahead of `s`, so `div_in` may be asynchronous to `in`. Latency grows by 2 cycles; `P`/`H` values are unchanged for a steady input.
  - Undefined: `div_in` must be synchronous to `in`, with a single sampling flop.

## Test plan
- SIZE=8, `enable`=1, `div_in` pattern high 2 / low 2 repeating -> after the second rise `upd` pulses once, `P`=4, `H`=2, `valid`=1; `upd` then repeats every 4 cycles with the same values.
- Pattern high 3 / low 4 -> `P`=7, `H`=3 on every `upd`.
- `div_in` toggling every cycle -> `P`=2, `H`=1.
- `div_in` held low for 300 cycles after one rise -> `err`=1 and `valid`=0 in the cycle after `cnt` reaches 255, with `P`=`H`=0. A later 4-cycle pattern gives `P`=4, `valid`=1, and `err` still 1 until `enable` is pulsed low.
- Drop `enable` mid-period, then re-raise it -> no `upd` for the partial period, `valid`=0, `err`=0. The first report after re-enable follows one discarded period.
- Assert `reset` low mid-MEASURE -> all outputs 0 immediately. After release, a high `div_in` produces no `upd` until two rises have been seen.
